// File: rtl/arqte1_sysid_checker.sv
// ---------------------------------------------------------------------------
// arqte1_sysid_checker
//
// Avalon-MM read master placed directly downstream of the system-ID slave.
// After reset (AUTO_START=1) or on a start pulse it reads word 0 (system ID)
// and word 1 (build timestamp). It compares both words against build-time
// constants and reports sticky status flags. Firmware and the boot-hold
// logic use these flags to refuse a mismatched hardware image.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   start               single-cycle request to (re)run the check
//   avm_address         word select (0 = ID, 1 = timestamp)
//   avm_read            read strobe
//   avm_waitrequest     slave stall
//   avm_readdata        slave read data (32 bit)
//   busy / done         check in progress / check finished (sticky)
//   id_ok / ts_ok       captured word equals its expected constant
//   match               id_ok AND ts_ok AND NOT timeout
//   timeout             a read was aborted on waitrequest timeout
//   id_value, ts_value  last captured ID / timestamp words
// ---------------------------------------------------------------------------
module arqte1_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1554393671,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_ID  = 3'd1,
    S_LAT_ID = 3'd2,
    S_RD_TS  = 3'd3,
    S_LAT_TS = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam bit          LAT_ZERO = (READ_LATENCY == 0);
  localparam logic [1:0]  LAT_INIT = 2'(READ_LATENCY);
  // Abort fires on the stalled edge that brings the count to TIMEOUT_CYCLES.
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  // Word comparison used for both the ID and the timestamp checks.
  function automatic logic word_equal(input logic [31:0] a, input logic [31:0] b);
    return (a == b);
  endfunction

  state_t      state_r, state_s;
  logic        pending_r, pending_s;
  logic        armed_r, armed_s;
  logic [1:0]  lat_cnt_r, lat_cnt_s;
  logic [15:0] stall_cnt_r, stall_cnt_s;
  logic        read_r, read_s;
  logic        addr_r, addr_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        id_ok_r, id_ok_s;
  logic        ts_ok_r, ts_ok_s;
  logic        match_r, match_s;
  logic        timeout_r, timeout_s;
  logic [31:0] id_value_r, id_value_s;
  logic [31:0] ts_value_r, ts_value_s;

  logic        accept_s;
  logic        stall_s;
  logic        start_req_s;

  // Next-state and next-output computation for the read sequencer.
  always_comb begin
    state_s     = state_r;
    pending_s   = pending_r;
    armed_s     = 1'b1;
    lat_cnt_s   = lat_cnt_r;
    stall_cnt_s = stall_cnt_r;
    read_s      = read_r;
    addr_s      = addr_r;
    busy_s      = busy_r;
    done_s      = done_r;
    id_ok_s     = id_ok_r;
    ts_ok_s     = ts_ok_r;
    match_s     = match_r;
    timeout_s   = timeout_r;
    id_value_s  = id_value_r;
    ts_value_s  = ts_value_r;

    accept_s    = read_r & ~avm_waitrequest;
    stall_s     = read_r & avm_waitrequest;
    // armed_r masks a start that is already high on the first edge after reset.
    start_req_s = (start & armed_r) | pending_r;

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_req_s) begin
          state_s     = S_RD_ID;
          pending_s   = 1'b0;
          stall_cnt_s = 16'd0;
          read_s      = 1'b1;
          addr_s      = 1'b0;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          id_ok_s     = 1'b0;
          ts_ok_s     = 1'b0;
          match_s     = 1'b0;
          timeout_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      S_RD_ID: begin
        if (accept_s) begin
          if (LAT_ZERO) begin
            id_value_s  = avm_readdata;
            state_s     = S_RD_TS;
            addr_s      = 1'b1;
            stall_cnt_s = 16'd0;
          end else begin
            read_s    = 1'b0;
            lat_cnt_s = LAT_INIT;
            state_s   = S_LAT_ID;
          end
        end else if (stall_s) begin
          stall_cnt_s = stall_cnt_r + 16'd1;
          if (stall_cnt_r == TO_LIMIT) begin
            state_s   = S_DONE;
            read_s    = 1'b0;
            busy_s    = 1'b0;
            done_s    = 1'b1;
            timeout_s = 1'b1;
            match_s   = 1'b0;
          end else begin
            state_s = S_RD_ID;
          end
        end else begin
          state_s = S_RD_ID;
        end
      end

      S_LAT_ID: begin
        if (lat_cnt_r == 2'd1) begin
          id_value_s  = avm_readdata;
          state_s     = S_RD_TS;
          read_s      = 1'b1;
          addr_s      = 1'b1;
          stall_cnt_s = 16'd0;
        end else begin
          lat_cnt_s = lat_cnt_r - 2'd1;
        end
      end

      S_RD_TS: begin
        if (accept_s) begin
          if (LAT_ZERO) begin
            ts_value_s = avm_readdata;
            state_s    = S_DONE;
            read_s     = 1'b0;
            busy_s     = 1'b0;
            done_s     = 1'b1;
            id_ok_s    = word_equal(id_value_r, EXPECTED_ID);
            ts_ok_s    = word_equal(avm_readdata, EXPECTED_TIMESTAMP);
            match_s    = word_equal(id_value_r, EXPECTED_ID) &
                         word_equal(avm_readdata, EXPECTED_TIMESTAMP);
            timeout_s  = 1'b0;
          end else begin
            read_s    = 1'b0;
            lat_cnt_s = LAT_INIT;
            state_s   = S_LAT_TS;
          end
        end else if (stall_s) begin
          stall_cnt_s = stall_cnt_r + 16'd1;
          if (stall_cnt_r == TO_LIMIT) begin
            // The ID word is already captured, so its flag is still meaningful.
            state_s   = S_DONE;
            read_s    = 1'b0;
            busy_s    = 1'b0;
            done_s    = 1'b1;
            timeout_s = 1'b1;
            match_s   = 1'b0;
            id_ok_s   = word_equal(id_value_r, EXPECTED_ID);
          end else begin
            state_s = S_RD_TS;
          end
        end else begin
          state_s = S_RD_TS;
        end
      end

      S_LAT_TS: begin
        if (lat_cnt_r == 2'd1) begin
          ts_value_s = avm_readdata;
          state_s    = S_DONE;
          read_s     = 1'b0;
          busy_s     = 1'b0;
          done_s     = 1'b1;
          id_ok_s    = word_equal(id_value_r, EXPECTED_ID);
          ts_ok_s    = word_equal(avm_readdata, EXPECTED_TIMESTAMP);
          match_s    = word_equal(id_value_r, EXPECTED_ID) &
                       word_equal(avm_readdata, EXPECTED_TIMESTAMP);
          timeout_s  = 1'b0;
        end else begin
          lat_cnt_s = lat_cnt_r - 2'd1;
        end
      end

      default: begin
        state_s = S_IDLE;
        read_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything except the auto-start request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      pending_r   <= AUTO_START;
      armed_r     <= 1'b0;
      lat_cnt_r   <= 2'd0;
      stall_cnt_r <= 16'd0;
      read_r      <= 1'b0;
      addr_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      id_ok_r     <= 1'b0;
      ts_ok_r     <= 1'b0;
      match_r     <= 1'b0;
      timeout_r   <= 1'b0;
      id_value_r  <= 32'd0;
      ts_value_r  <= 32'd0;
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      armed_r     <= armed_s;
      lat_cnt_r   <= lat_cnt_s;
      stall_cnt_r <= stall_cnt_s;
      read_r      <= read_s;
      addr_r      <= addr_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      id_ok_r     <= id_ok_s;
      ts_ok_r     <= ts_ok_s;
      match_r     <= match_s;
      timeout_r   <= timeout_s;
      id_value_r  <= id_value_s;
      ts_value_r  <= ts_value_s;
    end
  end

  assign avm_address = addr_r;
  assign avm_read    = read_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign id_ok       = id_ok_r;
  assign ts_ok       = ts_ok_r;
  assign match       = match_r;
  assign timeout     = timeout_r;
  assign id_value    = id_value_r;
  assign ts_value    = ts_value_r;

endmodule

// File: tb/tb_arqte1_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_arqte1_sysid_checker
//
// Directed bench for arqte1_sysid_checker. dut0 runs at READ_LATENCY=0 with
// auto-start; dut2 runs at READ_LATENCY=2 without auto-start. Both use
// TIMEOUT_CYCLES=8 and share clock and reset. Each drives a small sysid
// slave model; dut2's model returns data two cycles after acceptance and
// garbage otherwise.
// ---------------------------------------------------------------------------
module tb_arqte1_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1554393671;
  localparam logic [31:0] TS_BAD  = 32'd1554393670;

  logic        clock;
  logic        reset_n;

  logic        start0, wr0, rd0, addr0, busy0, done0, id_ok0, ts_ok0, match0, tmo0;
  logic [31:0] rdata0, idv0, tsv0;
  logic [31:0] mem0_id, mem0_ts;

  logic        start2, wr2, rd2, addr2, busy2, done2, id_ok2, ts_ok2, match2, tmo2;
  logic [31:0] rdata2, idv2, tsv2;
  logic [31:0] mem2_id, mem2_ts;
  logic        v1, v2, a1, a2;

  int vectors;
  int miscompares;
  int acc0;

  arqte1_sysid_checker #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS_GOOD),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(8), .AUTO_START(1'b1)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0),
    .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
    .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0), .match(match0),
    .timeout(tmo0), .id_value(idv0), .ts_value(tsv0)
  );

  arqte1_sysid_checker #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(TS_GOOD),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2),
    .avm_address(addr2), .avm_read(rd2), .avm_waitrequest(wr2), .avm_readdata(rdata2),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2), .match(match2),
    .timeout(tmo2), .id_value(idv2), .ts_value(tsv2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Zero-latency slave model for dut0.
  assign rdata0 = addr0 ? mem0_ts : mem0_id;

  // Counts accepted reads on dut0.
  always @(posedge clock) begin
    if (rd0 && !wr0) acc0 <= acc0 + 1;
  end

  // Latency-2 slave model for dut2.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; v2 <= 1'b0; a1 <= 1'b0; a2 <= 1'b0;
    end else begin
      v1 <= rd2 && !wr2; a1 <= addr2;
      v2 <= v1;          a2 <= a1;
    end
  end
  assign rdata2 = v2 ? (a2 ? mem2_ts : mem2_id) : 32'hDEAD_BEEF;

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++; if (rd0 !== 1'b0) begin miscompares++; $display("FAIL rst_read: got %b want 0", rd0); end
    vectors++; if (addr0 !== 1'b0) begin miscompares++; $display("FAIL rst_addr: got %b want 0", addr0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", done0); end
    vectors++; if (tsv0 !== 32'd0) begin miscompares++; $display("FAIL rst_tsv: got %0d want 0", tsv0); end
    // start held across reset release must be ignored
    start2 = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_auto_start();
    @(posedge clock); @(negedge clock);
    start2 = 1'b0;
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL start_at_release: busy2 got %b want 0", busy2); end
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL auto_busy: got %b want 1", busy0); end
    vectors++; if (rd0 !== 1'b1 || addr0 !== 1'b0) begin miscompares++; $display("FAIL auto_rd_id: read %b addr %b want 1 0", rd0, addr0); end
    @(posedge clock); @(negedge clock);
    vectors++; if (rd0 !== 1'b1 || addr0 !== 1'b1) begin miscompares++; $display("FAIL auto_rd_ts: read %b addr %b want 1 1", rd0, addr0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL auto_early_done: got %b want 0", done0); end
    @(posedge clock); @(negedge clock);
    vectors++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin miscompares++; $display("FAIL auto_done: done %b busy %b want 1 0", done0, busy0); end
    vectors++; if (match0 !== 1'b1) begin miscompares++; $display("FAIL auto_match: got %b want 1", match0); end
    vectors++; if (rd0 !== 1'b0) begin miscompares++; $display("FAIL auto_read_off: got %b want 0", rd0); end
    vectors++; if (idv0 !== 32'd0 || tsv0 !== TS_GOOD) begin miscompares++; $display("FAIL auto_values: id %0d ts %0d want 0 %0d", idv0, tsv0, TS_GOOD); end
  endtask

  task automatic test_ts_mismatch();
    mem0_ts = TS_BAD;
    start0 = 1'b1;
    @(posedge clock); @(negedge clock);
    start0 = 1'b0;
    vectors++; if (done0 !== 1'b0 || busy0 !== 1'b1 || match0 !== 1'b0) begin miscompares++; $display("FAIL mm_restart: done %b busy %b match %b want 0 1 0", done0, busy0, match0); end
    repeat (2) begin @(posedge clock); @(negedge clock); end
    vectors++; if (done0 !== 1'b1 || tmo0 !== 1'b0) begin miscompares++; $display("FAIL mm_done: done %b timeout %b want 1 0", done0, tmo0); end
    vectors++; if (id_ok0 !== 1'b1 || ts_ok0 !== 1'b0 || match0 !== 1'b0) begin miscompares++; $display("FAIL mm_flags: id_ok %b ts_ok %b match %b want 1 0 0", id_ok0, ts_ok0, match0); end
    vectors++; if (tsv0 !== TS_BAD) begin miscompares++; $display("FAIL mm_tsv: got %0d want %0d", tsv0, TS_BAD); end
    mem0_ts = TS_GOOD;
  endtask

  task automatic test_latency_waits();
    logic exp_rd;
    start2 = 1'b1;
    wr2 = 1'b1;
    @(posedge clock); @(negedge clock);
    start2 = 1'b0;
    vectors++; if (rd2 !== 1'b1 || addr2 !== 1'b0 || busy2 !== 1'b1) begin miscompares++; $display("FAIL lat_start: read %b addr %b busy %b want 1 0 1", rd2, addr2, busy2); end
    for (int i = 1; i <= 9; i++) begin
      if (i == 4) wr2 = 1'b0;
      @(posedge clock); @(negedge clock);
      exp_rd = (i <= 3) || (i == 6);
      vectors++; if (rd2 !== exp_rd) begin miscompares++; $display("FAIL lat_read_e%0d: got %b want %b", i, rd2, exp_rd); end
      if (i <= 3) begin
        vectors++; if (addr2 !== 1'b0) begin miscompares++; $display("FAIL lat_addr_hold_e%0d: got %b want 0", i, addr2); end
      end
      if (i == 6) begin
        vectors++; if (addr2 !== 1'b1) begin miscompares++; $display("FAIL lat_addr_ts: got %b want 1", addr2); end
      end
      vectors++; if (done2 !== (i == 9)) begin miscompares++; $display("FAIL lat_done_e%0d: got %b want %b", i, done2, (i == 9)); end
    end
    vectors++; if (match2 !== 1'b1 || idv2 !== 32'd0 || tsv2 !== TS_GOOD) begin miscompares++; $display("FAIL lat_result: match %b id %h ts %0d want 1 0 %0d", match2, idv2, tsv2, TS_GOOD); end
  endtask

  task automatic test_timeout();
    wr0 = 1'b1;
    start0 = 1'b1;
    @(posedge clock); @(negedge clock);
    start0 = 1'b0;
    vectors++; if (rd0 !== 1'b1) begin miscompares++; $display("FAIL to_start: read got %b want 1", rd0); end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); @(negedge clock);
      if (i < 8) begin
        vectors++; if (rd0 !== 1'b1 || done0 !== 1'b0) begin miscompares++; $display("FAIL to_stall_e%0d: read %b done %b want 1 0", i, rd0, done0); end
      end
    end
    vectors++; if (rd0 !== 1'b0 || done0 !== 1'b1 || busy0 !== 1'b0) begin miscompares++; $display("FAIL to_abort: read %b done %b busy %b want 0 1 0", rd0, done0, busy0); end
    vectors++; if (tmo0 !== 1'b1 || match0 !== 1'b0 || id_ok0 !== 1'b0 || ts_ok0 !== 1'b0) begin miscompares++; $display("FAIL to_flags: timeout %b match %b id_ok %b ts_ok %b want 1 0 0 0", tmo0, match0, id_ok0, ts_ok0); end
    wr0 = 1'b0;
  endtask

  task automatic test_busy_start();
    int base;
    base = acc0;
    start0 = 1'b1;
    @(posedge clock); @(negedge clock);
    // start stays high through the RD_ID edge: must be ignored
    @(posedge clock); @(negedge clock);
    start0 = 1'b0;
    @(posedge clock); @(negedge clock);
    vectors++; if (done0 !== 1'b1 || (acc0 - base) !== 2) begin miscompares++; $display("FAIL busy_first: done %b reads %0d want 1 2", done0, acc0 - base); end
    @(posedge clock); @(negedge clock);
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b1 || rd0 !== 1'b0) begin miscompares++; $display("FAIL busy_no_queue: busy %b done %b read %b want 0 1 0", busy0, done0, rd0); end
    start0 = 1'b1;
    @(posedge clock); @(negedge clock);
    start0 = 1'b0;
    vectors++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin miscompares++; $display("FAIL busy_rerun_clear: done %b busy %b want 0 1", done0, busy0); end
    repeat (2) begin @(posedge clock); @(negedge clock); end
    vectors++; if (done0 !== 1'b1 || match0 !== 1'b1 || (acc0 - base) !== 4) begin miscompares++; $display("FAIL busy_rerun: done %b match %b reads %0d want 1 1 4", done0, match0, acc0 - base); end
  endtask

  task automatic test_reset_mid_read();
    start0 = 1'b1;
    @(posedge clock); @(negedge clock);
    start0 = 1'b0;
    @(posedge clock); @(negedge clock);
    vectors++; if (rd0 !== 1'b1 || addr0 !== 1'b1) begin miscompares++; $display("FAIL mid_in_rd_ts: read %b addr %b want 1 1", rd0, addr0); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (rd0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin miscompares++; $display("FAIL mid_async: read %b busy %b done %b want 0 0 0", rd0, busy0, done0); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    vectors++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin miscompares++; $display("FAIL mid_rerun_busy: busy %b done %b want 1 0", busy0, done0); end
    @(posedge clock); @(negedge clock);
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL mid_no_partial: done got %b want 0", done0); end
    @(posedge clock); @(negedge clock);
    vectors++; if (done0 !== 1'b1 || match0 !== 1'b1) begin miscompares++; $display("FAIL mid_rerun_done: done %b match %b want 1 1", done0, match0); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    acc0 = 0;
    reset_n = 1'b0;
    start0 = 1'b0; wr0 = 1'b0;
    start2 = 1'b0; wr2 = 1'b0;
    mem0_id = 32'd0; mem0_ts = TS_GOOD;
    mem2_id = 32'd0; mem2_ts = TS_GOOD;
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_latency_waits();
    test_timeout();
    test_busy_start();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
